serial_frame_ctrl: RTL and testbench

//   Sequences an 8-bit serial-in/parallel-out shift datapath as a framed serial receiver.
//   - Frame format: start bit 0, WIDTH data bits MSB-first, optional parity bit, stop bit 1.
//   - Gates shifting with bit_tick and counts bits.
//   - Validates framing and presents each completed word on a valid/ready output.
//   - Sits between a serial pin/sampler and a parallel consumer.

---
 rtl/serial_frame_pkg.sv | 17 +
 rtl/serial_frame_ctrl_sipo_shift_reg.sv | 23 ++
 rtl/serial_frame_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_frame_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the framed serial receiver.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package serial_frame_pkg;

    // Default data bits per frame and shift datapath width
    localparam int SERIAL_WIDTH = 8;

    // Receiver sequencing states; PARITY is only entered in parity builds
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

endpackage

// File: rtl/serial_frame_ctrl_sipo_shift_reg.sv
// Serial-in/parallel-out shift register, MSB-first (new bit enters at bit 0).
// Latency: data_out reflects a shifted bit one clk after shift_en.
// Backpressure: none; shifts whenever shift_en is high.
module sipo_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out
);

    // Shift left, inserting the new serial bit at the LSB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (shift_en) begin
            data_out <= {data_out[WIDTH-2:0], data_in};
        end
    end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Framed serial receiver (start, WIDTH data MSB-first, [parity], stop); parity via SERIAL_PARITY_EN.
// Latency: out_valid rises 1 clk after the stop-bit tick; error/overrun pulses also 1 clk after it.
// Backpressure: holds one word on out_valid/out_ready; a good frame arriving while held and not consumed is dropped (overrun).
module serial_frame_ctrl
    import serial_frame_pkg::*;
#(
    parameter int WIDTH      = SERIAL_WIDTH,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_tick,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sr;
    logic             shift_en;
    logic             stop_tick;
    logic             parity_ok;
    logic             word_good;
    logic             load_word;

    sipo_shift_reg #(.WIDTH(WIDTH)) u_sipo (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .data_in  (serial_in),
        .data_out (sr)
    );

    assign shift_en  = bit_tick && (state == DATA);
    assign stop_tick = bit_tick && (state == STOP);
    assign word_good = stop_tick && serial_in && parity_ok;
    // A completed word may load if the holding slot is empty or is being consumed now
    assign load_word = word_good && (!out_valid || out_ready);
    assign busy      = (state != IDLE);

`ifdef SERIAL_PARITY_EN
    // Capture the parity verdict on the parity tick; it is consumed at the stop tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_ok <= 1'b0;
        end else if (bit_tick && (state == PARITY)) begin
            parity_ok <= ((^sr) ^ serial_in) == PARITY_ODD;
        end
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
    assign parity_ok         = 1'b1;
`endif

    // Frame sequencer: one state step per bit tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else if (bit_tick) begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!serial_in) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(WIDTH - 1)) begin
`ifdef SERIAL_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end
                end
                PARITY: begin
                    state <= STOP;
                end
                STOP: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Output holding register, handshake and status pulses (evaluated every cycle)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_tick && !(serial_in && parity_ok);
            overrun   <= word_good && !load_word;
            if (load_word) begin
                out_data  <= sr;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed self-checking bench for serial_frame_ctrl.
module tb_serial_frame_ctrl;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic       bit_tick;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int checks;
    int failures;

    serial_frame_ctrl #(.WIDTH(8), .PARITY_ODD(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .bit_tick  (bit_tick),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one bit with a tick; called at a negedge, returns at the next negedge
    task automatic send_bit(input logic b);
        serial_in = b;
        bit_tick  = 1'b1;
        @(negedge clk);
        bit_tick  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        serial_in = 1'b1;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Start bit plus data bits MSB-first (plus parity bit in parity builds); no stop bit
    task automatic send_head(input logic [7:0] d, input logic pbit, input int gap);
        send_bit(1'b0);
        idle_cycles(gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]);
            idle_cycles(gap);
        end
`ifdef SERIAL_PARITY_EN
        send_bit(pbit);
        idle_cycles(gap);
`else
        if (pbit) serial_in = 1'b1;
`endif
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        serial_in = 1'b1;
        bit_tick  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Idle line high with a tick stays idle
        send_bit(1'b1);
        check("idle_high_busy", {31'd0, busy}, 32'd0);

        // Good frame 0xA5, consumer ready, back-to-back ticks
        out_ready = 1'b1;
        send_head(8'hA5, 1'b0, 0);
        check("a5_busy_before_stop", {31'd0, busy}, 32'd1);
        check("a5_valid_before_stop", {31'd0, out_valid}, 32'd0);
        send_bit(1'b1);
        check("a5_valid", {31'd0, out_valid}, 32'd1);
        check("a5_data", {24'd0, out_data}, 32'hA5);
        check("a5_busy_after", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("a5_consumed", {31'd0, out_valid}, 32'd0);

        // Load a held word, then reset mid-DATA
        out_ready = 1'b0;
        send_head(8'h5A, 1'b0, 1);
        send_bit(1'b1);
        check("5a_held_data", {24'd0, out_data}, 32'h5A);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("mid_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_data", {24'd0, out_data}, 32'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_head(8'h81, 1'b0, 0);
        send_bit(1'b1);
        check("post_rst_data", {24'd0, out_data}, 32'h81);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_consumed", {31'd0, out_valid}, 32'd0);

        // Bad stop bit
        send_head(8'h77, 1'b0, 0);
        send_bit(1'b0);
        check("badstop_err", {31'd0, frame_err}, 32'd1);
        check("badstop_valid", {31'd0, out_valid}, 32'd0);
        check("badstop_busy", {31'd0, busy}, 32'd0);
        idle_cycles(1);
        check("badstop_err_pulse", {31'd0, frame_err}, 32'd0);

        // Two frames with consumer stalled: second is dropped
        out_ready = 1'b0;
        send_head(8'h3C, 1'b0, 0);
        send_bit(1'b1);
        check("3c_data", {24'd0, out_data}, 32'h3C);
        check("3c_overrun", {31'd0, overrun}, 32'd0);
        send_head(8'hC3, 1'b0, 1);
        send_bit(1'b1);
        check("c3_overrun", {31'd0, overrun}, 32'd1);
        check("c3_data_kept", {24'd0, out_data}, 32'h3C);
        check("c3_valid", {31'd0, out_valid}, 32'd1);
        idle_cycles(1);
        check("c3_overrun_pulse", {31'd0, overrun}, 32'd0);

        // Consume and load in the same cycle
        send_head(8'h96, 1'b0, 0);
        out_ready = 1'b1;
        send_bit(1'b1);
        out_ready = 1'b0;
        check("swap_data", {24'd0, out_data}, 32'h96);
        check("swap_valid", {31'd0, out_valid}, 32'd1);
        check("swap_overrun", {31'd0, overrun}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("swap_consumed", {31'd0, out_valid}, 32'd0);

`ifdef SERIAL_PARITY_EN
        // Even parity: 0x01 with parity 0 is bad, with parity 1 is good
        send_head(8'h01, 1'b0, 0);
        send_bit(1'b1);
        check("par_bad_err", {31'd0, frame_err}, 32'd1);
        check("par_bad_valid", {31'd0, out_valid}, 32'd0);
        send_head(8'h01, 1'b1, 0);
        send_bit(1'b1);
        check("par_good_err", {31'd0, frame_err}, 32'd0);
        check("par_good_data", {24'd0, out_data}, 32'h01);
        check("par_good_valid", {31'd0, out_valid}, 32'd1);
`endif

        idle_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
